// File: rtl/sseg_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan controller.
// Segment bit 0 is segment a; bit 7 of a stored pattern is the decimal point.
package sseg_pkg;

    typedef logic [7:0] seg_pat_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex digit to active-high segment pattern (bit 0 = a).
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with a shadow/active pattern buffer.
// Shadow writes land in the active buffer only at a frame wrap or while disabled.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter  int NUM_DIGITS   = 8,
    parameter  int DWELL_CYCLES = 1000,
    parameter  int BLANK_CYCLES = 16,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic                  wr_hex,
    input  logic [7:0]            wr_data,
    input  logic                  commit,
    output logic                  commit_done,
    output logic                  frame_start,
    output logic [6:0]            sseg_segment_n,
    output logic                  sseg_decimal_point_n,
    output logic [NUM_DIGITS-1:0] sseg_digit_n
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      digit_q, digit_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic                  pending_q, pending_d;
    logic                  commit_done_q;
    logic                  frame_start_q, frame_start_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;

    seg_pat_t shadow_q [NUM_DIGITS];
    seg_pat_t active_q [NUM_DIGITS];

    logic       wrap;
    logic       apply;
    logic       wr_fire;
    logic [6:0] hex_seg;
    seg_pat_t   wr_pat;

    sseg_hex_decode u_hex_decode (
        .hex (wr_data[3:0]),
        .seg (hex_seg)
    );

    // Handshake: a write transfers on any edge where wr_valid && wr_ready; wr_ready
    // depends only on registered state (low from commit request until after the copy).
    assign wr_ready = !pending_q && !commit_done_q;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_pat   = wr_hex ? {wr_data[7], hex_seg} : wr_data;

    // Scan sequencing; run_q low means the next enabled edge restarts at BLANK(0).
    always_comb begin
        state_d       = state_q;
        digit_d       = digit_q;
        cnt_d         = cnt_q;
        run_d         = run_q;
        frame_start_d = 1'b0;
        wrap          = 1'b0;
        if (!enable) begin
            state_d = BLANK;
            digit_d = '0;
            cnt_d   = '0;
            run_d   = 1'b0;
        end else if (!run_q) begin
            state_d       = BLANK;
            digit_d       = '0;
            cnt_d         = '0;
            run_d         = 1'b1;
            frame_start_d = 1'b1;
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (digit_q == DIGIT_LAST) begin
                            digit_d       = '0;
                            wrap          = 1'b1;
                            frame_start_d = 1'b1;
                        end else begin
                            digit_d = digit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // A commit seen on the wrap edge itself only becomes pending, so it waits a frame.
    always_comb begin
        apply     = pending_q && (wrap || !enable);
        pending_d = pending_q;
        if (apply) begin
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end
    end

    // Display drive is computed from the next state so pins track the state register.
    always_comb begin
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        dig_n_d = '1;
        if (state_d == DRIVE) begin
            dig_n_d = ~(NUM_DIGITS'(1) << digit_d);
            seg_n_d = ~active_q[digit_d][6:0];
            dp_n_d  = ~active_q[digit_d][7];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BLANK;
            digit_q       <= '0;
            cnt_q         <= '0;
            run_q         <= 1'b0;
            pending_q     <= 1'b0;
            commit_done_q <= 1'b0;
            frame_start_q <= 1'b0;
            seg_n_q       <= 7'h7F;
            dp_n_q        <= 1'b1;
            dig_n_q       <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            pending_q     <= pending_d;
            commit_done_q <= apply;
            frame_start_q <= frame_start_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
            dig_n_q       <= dig_n_d;
            if (wr_fire && (int'(wr_idx) < NUM_DIGITS)) begin
                shadow_q[wr_idx] <= wr_pat;
            end
            if (apply) begin
                active_q <= shadow_q;
            end
        end
    end

    assign commit_done          = commit_done_q;
    assign frame_start          = frame_start_q;
    assign sseg_segment_n       = seg_n_q;
    assign sseg_decimal_point_n = dp_n_q;
    assign sseg_digit_n         = dig_n_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl: 4-digit instance for scan/commit behaviour,
// 5-digit instance for the out-of-range write index.
module tb_sseg_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, wr_valid, wr_hex, commit;
    logic [1:0] wr_idx;
    logic [7:0] wr_data;
    logic       wr_ready, commit_done, frame_start;
    logic [6:0] sseg_segment_n;
    logic       sseg_decimal_point_n;
    logic [3:0] sseg_digit_n;

    logic       wr_valid5, commit5;
    logic [2:0] wr_idx5;
    logic       wr_ready5, commit_done5, frame_start5;
    logic [6:0] seg5;
    logic       dp5;
    logic [4:0] dig5;

    int n_tests = 0;
    int n_fail  = 0;

    sseg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) u_dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .wr_valid             (wr_valid),
        .wr_ready             (wr_ready),
        .wr_idx               (wr_idx),
        .wr_hex               (wr_hex),
        .wr_data              (wr_data),
        .commit               (commit),
        .commit_done          (commit_done),
        .frame_start          (frame_start),
        .sseg_segment_n       (sseg_segment_n),
        .sseg_decimal_point_n (sseg_decimal_point_n),
        .sseg_digit_n         (sseg_digit_n)
    );

    sseg_scan_ctrl #(.NUM_DIGITS(5), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) u_dut5 (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .wr_valid             (wr_valid5),
        .wr_ready             (wr_ready5),
        .wr_idx               (wr_idx5),
        .wr_hex               (wr_hex),
        .wr_data              (wr_data),
        .commit               (commit5),
        .commit_done          (commit_done5),
        .frame_start          (frame_start5),
        .sseg_segment_n       (seg5),
        .sseg_decimal_point_n (dp5),
        .sseg_digit_n         (dig5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] dig, input logic [6:0] seg,
                            input logic dp);
        chk({tag, "_digit"}, sseg_digit_n, dig);
        chk({tag, "_seg"}, sseg_segment_n, seg);
        chk({tag, "_dp"}, sseg_decimal_point_n, dp);
    endtask

    task automatic wait_cd(input int budget, output int n);
        int k;
        for (k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (commit_done === 1'b1) break;
        end
        n = k;
    endtask

    task automatic wait_fs(input int budget, output int n);
        int k;
        for (k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) break;
        end
        n = k;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic bad;
        logic seen;

        reset = 1'b0; enable = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_hex = 1'b0;
        wr_data = '0; commit = 1'b0; wr_valid5 = 1'b0; wr_idx5 = '0; commit5 = 1'b0;
        #1 reset = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk_disp("rst", 4'hF, 7'h7F, 1'b1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_commit_done", commit_done, 0);
        chk("rst_frame_start", frame_start, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_frame_start", frame_start, 1);
        chk("first_blank_digit", sseg_digit_n, 4'hF);

        // Hex write of 3 with dp to digit 0, then commit
        chk("wr_ready_idle", wr_ready, 1);
        wr_valid = 1'b1; wr_idx = 2'd0; wr_hex = 1'b1; wr_data = 8'h83;
        @(negedge clk);
        wr_valid = 1'b0; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        chk("pending_blocks_ready", wr_ready, 0);
        wait_cd(40, n);
        chk("commit_done_seen", n <= 40, 1);
        chk("commit_done_at_frame_start", frame_start, 1);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) chk("ready_low_on_done", wr_ready, 0);
            if (c == 1) chk("ready_back_after_done", wr_ready, 1);
            if (c >= 2 && c <= 5) chk_disp("drive0_hex3", 4'hE, 7'h30, 1'b0);
            else chk_disp("blank_around_drive0", 4'hF, 7'h7F, 1'b1);
        end

        // Hex E to digit 3, then raw 0x49 to digit 2 with commit in the same cycle
        wr_valid = 1'b1; wr_idx = 2'd3; wr_hex = 1'b1; wr_data = 8'h0E;
        @(negedge clk);
        chk("ready_before_raw", wr_ready, 1);
        wr_idx = 2'd2; wr_hex = 1'b0; wr_data = 8'h49; commit = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; commit = 1'b0;
        chk("ready_low_after_commit", wr_ready, 0);
        bad = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (wr_ready !== 1'b0) bad = 1'b1;
            if (commit_done === 1'b1) break;
        end
        chk("raw_commit_done_seen", n <= 40, 1);
        chk("ready_held_low_until_done", bad, 0);
        @(negedge clk);
        chk("ready_after_raw_done", wr_ready, 1);
        @(negedge clk);
        chk_disp("drive0_kept", 4'hE, 7'h30, 1'b0);
        repeat (12) @(negedge clk);
        chk_disp("drive2_raw49", 4'hB, 7'h36, 1'b1);
        repeat (6) @(negedge clk);
        chk_disp("drive3_hexE", 4'h7, 7'h06, 1'b1);

        // Frame period and commit on the wrap cycle
        wait_fs(30, n);
        chk("frame_start_seen", n <= 30, 1);
        wait_fs(40, n);
        chk("frame_period", n, 24);
        repeat (23) @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        chk("wrap_commit_frame_start", frame_start, 1);
        chk("wrap_commit_not_now", commit_done, 0);
        for (n = 1; n <= 40; n++) begin
            commit = (n == 5);
            @(negedge clk);
            if (commit_done === 1'b1) break;
        end
        commit = 1'b0;
        chk("wrap_commit_latency", n, 24);
        @(negedge clk);
        chk("ready_after_wrap_commit", wr_ready, 1);
        bad = 1'b0;
        repeat (29) begin
            @(negedge clk);
            if (commit_done !== 1'b0) bad = 1'b1;
        end
        chk("no_second_commit", bad, 0);

        // Enable drop mid DRIVE(1) with a pending commit
        wait_fs(30, n);
        chk("frame_start_before_enable", n <= 30, 1);
        @(negedge clk);
        chk("ready_before_enable_test", wr_ready, 1);
        wr_valid = 1'b1; wr_idx = 2'd1; wr_hex = 1'b1; wr_data = 8'h05;
        @(negedge clk);
        wr_valid = 1'b0; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        repeat (6) @(negedge clk);
        chk("drive1_before_drop", sseg_digit_n, 4'hD);
        enable = 1'b0;
        @(negedge clk);
        chk_disp("disabled_blank", 4'hF, 7'h7F, 1'b1);
        chk("disable_applies_commit", commit_done, 1);
        chk("disable_no_frame_start", frame_start, 0);
        @(negedge clk);
        chk("disabled_done_clears", commit_done, 0);
        chk("disabled_ready", wr_ready, 1);
        wr_valid = 1'b1; wr_idx = 2'd0; wr_hex = 1'b0; wr_data = 8'h7F;
        @(negedge clk);
        wr_valid = 1'b0; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        chk("disabled_pending", wr_ready, 0);
        @(negedge clk);
        chk("disabled_commit_applied", commit_done, 1);
        chk("disabled_still_blank", sseg_digit_n, 4'hF);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("reenable_frame_start", frame_start, 1);
        chk("reenable_blank0", sseg_digit_n, 4'hF);
        @(negedge clk);
        chk("reenable_blank1", sseg_digit_n, 4'hF);
        @(negedge clk);
        chk_disp("reenable_drive0_raw7f", 4'hE, 7'h00, 1'b1);
        repeat (6) @(negedge clk);
        chk_disp("reenable_drive1_hex5", 4'hD, 7'h12, 1'b1);

        // Asynchronous reset while a digit is lit
        #2 reset = 1'b1;
        #1;
        chk_disp("async_rst", 4'hF, 7'h7F, 1'b1);
        chk("async_rst_ready", wr_ready, 1);
        chk("async_rst_done", commit_done, 0);
        chk("async_rst_fs", frame_start, 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0; seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (sseg_segment_n !== 7'h7F || sseg_decimal_point_n !== 1'b1) bad = 1'b1;
            if (sseg_digit_n !== 4'hF) seen = 1'b1;
        end
        chk("post_rst_active_clear", bad, 0);
        chk("post_rst_scanning", seen, 1);
        chk("post_rst_ready", wr_ready, 1);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        wait_cd(40, n);
        chk("post_rst_commit_seen", n <= 40, 1);
        bad = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (sseg_segment_n !== 7'h7F || sseg_decimal_point_n !== 1'b1) bad = 1'b1;
        end
        chk("post_rst_shadow_clear", bad, 0);

        // Out-of-range index on the 5-digit instance
        chk("oor_ready", wr_ready5, 1);
        wr_valid5 = 1'b1; wr_idx5 = 3'd5; wr_hex = 1'b1; wr_data = 8'h88;
        @(negedge clk);
        wr_valid5 = 1'b0; commit5 = 1'b1;
        @(negedge clk);
        commit5 = 1'b0;
        for (n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (commit_done5 === 1'b1) break;
        end
        chk("oor_commit_seen", n <= 50, 1);
        bad = 1'b0; seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (seg5 !== 7'h7F || dp5 !== 1'b1) bad = 1'b1;
            if (dig5 !== 5'h1F) seen = 1'b1;
        end
        chk("oor_no_change", bad, 0);
        chk("oor_scanning", seen, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
